// File: rtl/bram_stream_reader_if.sv
// Valid/ready word stream with a final-word marker, as driven by the BRAM read engine.
interface bram_stream_reader_if #(
   parameter int unsigned WIDTH = 18
) ();
   logic [WIDTH-1:0] data;
   logic             valid;
   logic             ready;
   logic             last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/bram_stream_reader.sv
// Sweeps a wrapping BRAM address range and streams the words out through a skid FIFO
// sized to absorb the RAM read latency under downstream backpressure.
module bram_stream_reader #(
   parameter int unsigned RAM_WIDTH    = 18,
   parameter int unsigned RAM_DEPTH    = 1024,
   parameter int unsigned READ_LATENCY = 2,
   parameter int unsigned FIFO_DEPTH   = 4,
   localparam int unsigned ADDR_W      = $clog2(RAM_DEPTH)
) (
   input  logic                  clka,
   input  logic                  rstb,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     mem_addrb,
   output logic                  mem_enb,
   output logic                  mem_regceb,
   input  logic [RAM_WIDTH-1:0]  mem_doutb,
   bram_stream_reader_if.master  m
);
   localparam int unsigned LEN_W = ADDR_W + 1;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, last_addr_q;
   logic [LEN_W-1:0]        remaining_q;
   logic [CNT_W-1:0]        outstanding_q, count_q;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_last_q;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [RAM_WIDTH:0]      fifo_mem [FIFO_DEPTH];
   logic [RAM_WIDTH:0]      head;
   logic                    fifo_vld, issue, pop, push, load, done_d, cmd_last;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head     = fifo_mem[rd_ptr_q];
   assign fifo_vld = (count_q != '0);
   assign pop      = fifo_vld & m.ready;
   assign push     = pipe_vld_q[READ_LATENCY-1];
   assign cmd_last = (remaining_q == LEN_W'(1));

   // State register
   always_ff @(posedge clka) begin
      if (rstb) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && length != '0) state_d = RUN;
         RUN:     if (issue && cmd_last) state_d = DRAIN;
         DRAIN:   if (pop && head[RAM_WIDTH]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/control logic; issue counts a same-cycle pop as a freed slot
   always_comb begin
      issue  = 1'b0;
      load   = 1'b0;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) load   = 1'b1;
               else              done_d = 1'b1;
            end
         end
         RUN:     issue  = (remaining_q != '0) &&
                           ((outstanding_q - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH));
         DRAIN:   done_d = pop && head[RAM_WIDTH];
         default: ;
      endcase
   end

   // Address/length counters, latency pipe, FIFO pointers and status flags
   always_ff @(posedge clka) begin
      if (rstb) begin
         addr_q        <= '0;
         last_addr_q   <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         pipe_vld_q    <= '0;
         pipe_last_q   <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
      end else begin
         if (load) begin
            addr_q      <= base_addr;
            remaining_q <= length;
         end else if (issue) begin
            addr_q      <= (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
            remaining_q <= remaining_q - LEN_W'(1);
            last_addr_q <= addr_q;
         end
         pipe_vld_q    <= (pipe_vld_q << 1) | READ_LATENCY'(issue);
         pipe_last_q   <= (pipe_last_q << 1) | READ_LATENCY'(issue && cmd_last);
         outstanding_q <= outstanding_q + CNT_W'(issue) - CNT_W'(pop);
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q       <= count_q + CNT_W'(push) - CNT_W'(pop);
         done          <= done_d;
         busy          <= (state_d != IDLE);
      end
   end

   // FIFO storage: data word plus its last flag
   always_ff @(posedge clka) begin
      if (push) fifo_mem[wr_ptr_q] <= {pipe_last_q[READ_LATENCY-1], mem_doutb};
   end

   assign mem_enb    = issue;
   assign mem_addrb  = issue ? addr_q : last_addr_q;
   assign mem_regceb = 1'b1;
   assign m.valid    = fifo_vld;
   assign m.data     = fifo_vld ? head[RAM_WIDTH-1:0] : '0;
   assign m.last     = fifo_vld & head[RAM_WIDTH];
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: a 2-cycle and a 1-cycle latency instance share the stimulus
// and are checked against a word-list model of the RAM sweep.
module tb_bram_stream_reader;
   localparam int unsigned W     = 18;
   localparam int unsigned DEPTH = 1024;
   localparam int unsigned AW    = 10;
   localparam int unsigned LW    = AW + 1;

   typedef struct { int cyc; logic [W-1:0] data; logic last; } hs_t;
   typedef struct { logic [W-1:0] data; logic last; } word_t;

   logic          clka = 1'b0, rstb = 1'b1, start = 1'b0, ready = 1'b1;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] length = '0;
   logic          busy0, done0, enb0, regceb0, busy1, done1, enb1, regceb1;
   logic [AW-1:0] addrb0, addrb1;
   logic [W-1:0]  r0a = '0, r0b = '0, r1a = '0;
   logic [W-1:0]  ram [DEPTH];

   int cyc = 0, t0 = 0, rmode = 0, passed = 0, total = 0;

   hs_t   hs0[$], hs1[$];
   word_t exp_q[$];
   int    en_c0[$], en_c1[$], dn0[$], dn1[$];
   int    en_a0[$], en_a1[$];
   bit    busy_seen0, busy_seen1;
   int    fv0, fv1, stall_bad0, stall_bad1, out0, out1, max0, max1;
   logic  pv0, pr0, pl0, pv1, pr1, pl1;
   logic [W-1:0] pd0, pd1;

   bram_stream_reader_if #(.WIDTH(W)) s0 ();
   bram_stream_reader_if #(.WIDTH(W)) s1 ();
   assign s0.ready = ready;
   assign s1.ready = ready;

   bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut (
      .clka(clka), .rstb(rstb), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy0), .done(done0), .mem_addrb(addrb0), .mem_enb(enb0), .mem_regceb(regceb0),
      .mem_doutb(r0b), .m(s0));

   bram_stream_reader #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
      .clka(clka), .rstb(rstb), .start(start), .base_addr(base_addr), .length(length),
      .busy(busy1), .done(done1), .mem_addrb(addrb1), .mem_enb(enb1), .mem_regceb(regceb1),
      .mem_doutb(r1a), .m(s1));

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   // RAM read ports: 2-cycle (output register) and 1-cycle configurations; rstb does not touch them
   always @(posedge clka) begin
      if (enb0) r0a <= ram[addrb0];
      if (regceb0) r0b <= r0a;
      if (enb1) r1a <= ram[addrb1];
   end

   // Downstream ready pattern, driven just after each active edge
   initial forever begin
      @(posedge clka); #1;
      case (rmode)
         0:       ready = 1'b1;
         1:       ready = ($urandom_range(0, 3) != 0);
         default: ready = ((cyc - t0) >= 3 && (cyc - t0) <= 12) ? 1'b0 : 1'($urandom_range(0, 1));
      endcase
   end

   // Observer: logs issues, handshakes, done pulses and stall stability on the falling edge
   initial begin : mon
      hs_t h;
      forever begin
         @(negedge clka);
         if (s0.valid && s0.ready) begin h.cyc = cyc - t0; h.data = s0.data; h.last = s0.last; hs0.push_back(h); end
         if (s1.valid && s1.ready) begin h.cyc = cyc - t0; h.data = s1.data; h.last = s1.last; hs1.push_back(h); end
         if (enb0) begin en_c0.push_back(cyc - t0); en_a0.push_back(int'(addrb0)); end
         if (enb1) begin en_c1.push_back(cyc - t0); en_a1.push_back(int'(addrb1)); end
         if (done0) dn0.push_back(cyc - t0);
         if (done1) dn1.push_back(cyc - t0);
         if (busy0) busy_seen0 = 1'b1;
         if (busy1) busy_seen1 = 1'b1;
         if (s0.valid && fv0 < 0) fv0 = cyc - t0;
         if (s1.valid && fv1 < 0) fv1 = cyc - t0;
         if (pv0 && !pr0 && (!s0.valid || s0.data !== pd0 || s0.last !== pl0)) stall_bad0++;
         if (pv1 && !pr1 && (!s1.valid || s1.data !== pd1 || s1.last !== pl1)) stall_bad1++;
         pv0 = s0.valid; pr0 = s0.ready; pd0 = s0.data; pl0 = s0.last;
         pv1 = s1.valid; pr1 = s1.ready; pd1 = s1.data; pl1 = s1.last;
         out0 = out0 + int'(enb0) - int'(s0.valid && s0.ready);
         out1 = out1 + int'(enb1) - int'(s1.valid && s1.ready);
         if (out0 > max0) max0 = out0;
         if (out1 > max1) max1 = out1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
      $fatal(1);
   end

   // Reference: the command streams RAM[(base+k) mod DEPTH] for k = 0..len-1, last on the final word
   function automatic void build_exp(input int base, input int len);
      word_t w;
      exp_q.delete();
      for (int k = 0; k < len; k++) begin
         w.data = ram[(base + k) % DEPTH];
         w.last = (k == len - 1);
         exp_q.push_back(w);
      end
   endfunction

   // First index where an observed stream departs from the reference (-2: count differs, -1: none)
   function automatic int stream_err(input hs_t q[$]);
      if (q.size() != exp_q.size()) return -2;
      foreach (q[i]) if (q[i].data !== exp_q[i].data || q[i].last !== exp_q[i].last) return i;
      return -1;
   endfunction

   function automatic void clear_logs();
      hs0.delete(); hs1.delete(); en_c0.delete(); en_c1.delete(); en_a0.delete(); en_a1.delete();
      dn0.delete(); dn1.delete();
      busy_seen0 = 1'b0; busy_seen1 = 1'b0; fv0 = -1; fv1 = -1;
      stall_bad0 = 0; stall_bad1 = 0; out0 = 0; out1 = 0; max0 = 0; max1 = 0;
      pv0 = 1'b0; pv1 = 1'b0;
   endfunction

   function automatic void fill_ram();
      foreach (ram[i]) ram[i] = W'($urandom);
   endfunction

   // Cycle 0 is the cycle in which start is sampled; now=1 starts in the current cycle
   task automatic issue_start(input int base, input int len, input bit now);
      if (!now) begin @(posedge clka); #1; end
      clear_logs();
      t0 = cyc; base_addr = AW'(base); length = LW'(len); start = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clka);
         if (dn0.size() > 0 && dn1.size() > 0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      logic [33:0] got0, got1;
      rstb = 1'b1;
      repeat (3) @(posedge clka);
      #1 rstb = 1'b0;
      @(negedge clka);
      got0 = {busy0, done0, s0.valid, s0.last, s0.data, enb0, addrb0, regceb0};
      got1 = {busy1, done1, s1.valid, s1.last, s1.data, enb1, addrb1, regceb1};
      total++; if (got0 !== 34'h1) $display("FAIL reset_l2: outputs %h, required %h", got0, 34'h1); else passed++;
      total++; if (got1 !== 34'h1) $display("FAIL reset_l1: outputs %h, required %h", got1, 34'h1); else passed++;
   endtask

   task automatic test_basic();
      bit ok, bad;
      int e;
      foreach (ram[i]) ram[i] = W'(i);
      rmode = 0;
      build_exp(0, 8);
      issue_start(0, 8, 1'b0);
      wait_done(100, ok);
      repeat (2) @(negedge clka);
      total++; if (!ok) $display("FAIL basic_timeout: done not seen in 100 cycles"); else passed++;
      bad = (en_c0.size() != 8);
      foreach (en_c0[i]) if (en_c0[i] != i + 1 || en_a0[i] != i) bad = 1'b1;
      total++; if (bad) $display("FAIL basic_issue: %0d reads, required 8 reads at cycles 1..8 addr 0..7", en_c0.size()); else passed++;
      e = stream_err(hs0);
      total++; if (e != -1) $display("FAIL basic_stream: error at %0d, got %0d words, required 8", e, hs0.size()); else passed++;
      bad = (hs0.size() != 8);
      foreach (hs0[i]) if (hs0[i].cyc != i + 4) bad = 1'b1;
      total++; if (bad) $display("FAIL basic_timing: first handshake cycle %0d, required words in cycles 4..11",
                                 (hs0.size() > 0) ? hs0[0].cyc : -1); else passed++;
      total++; if (dn0.size() != 1 || dn0[0] != 12) $display("FAIL basic_done: %0d pulses, cycle %0d, required one at 12",
                                 dn0.size(), (dn0.size() > 0) ? dn0[0] : -1); else passed++;
      total++; if (fv1 != 3 || stream_err(hs1) != -1) $display("FAIL basic_l1: first valid %0d, required 3; stream error %0d",
                                 fv1, stream_err(hs1)); else passed++;
   endtask

   task automatic test_backpressure();
      bit ok;
      int e0, e1;
      fill_ram();
      rmode = 2;
      build_exp(0, 16);
      issue_start(0, 16, 1'b0);
      wait_done(400, ok);
      repeat (2) @(negedge clka);
      rmode = 0;
      total++; if (!ok) $display("FAIL bp_timeout: done not seen in 400 cycles"); else passed++;
      total++; if (max0 != 4 || max1 != 4) $display("FAIL bp_outstanding: max %0d/%0d, required 4/4", max0, max1); else passed++;
      e0 = stream_err(hs0); e1 = stream_err(hs1);
      total++; if (e0 != -1) $display("FAIL bp_stream_l2: error at %0d, got %0d words, required 16", e0, hs0.size()); else passed++;
      total++; if (e1 != -1) $display("FAIL bp_stream_l1: error at %0d, got %0d words, required 16", e1, hs1.size()); else passed++;
      total++; if (stall_bad0 != 0 || stall_bad1 != 0) $display("FAIL bp_stable: %0d/%0d unstable stall cycles, required 0",
                                 stall_bad0, stall_bad1); else passed++;
   endtask

   task automatic test_wrap();
      bit ok, bad;
      int exp_a[4];
      exp_a = '{1022, 1023, 0, 1};
      fill_ram();
      rmode = 0;
      build_exp(1022, 4);
      issue_start(1022, 4, 1'b0);
      wait_done(100, ok);
      repeat (2) @(negedge clka);
      bad = !ok || en_a0.size() != 4 || en_a1.size() != 4;
      foreach (en_a0[i]) if (i < 4 && (en_a0[i] != exp_a[i] || en_a1[i] != exp_a[i])) bad = 1'b1;
      total++; if (bad) $display("FAIL wrap_addr: %0d reads, first %0d, required 1022 1023 0 1",
                                 en_a0.size(), (en_a0.size() > 0) ? en_a0[0] : -1); else passed++;
      total++; if (stream_err(hs0) != -1 || stream_err(hs1) != -1) $display("FAIL wrap_stream: errors %0d/%0d, required none",
                                 stream_err(hs0), stream_err(hs1)); else passed++;
   endtask

   task automatic test_zero_len();
      rmode = 0;
      issue_start(7, 0, 1'b0);
      repeat (4) @(negedge clka);
      total++; if (en_c0.size() != 0 || en_c1.size() != 0 || hs0.size() != 0 || hs1.size() != 0)
         $display("FAIL zero_reads: %0d/%0d reads, %0d/%0d words, required none", en_c0.size(), en_c1.size(), hs0.size(), hs1.size());
      else passed++;
      total++; if (dn0.size() != 1 || dn0[0] != 1 || dn1.size() != 1 || dn1[0] != 1)
         $display("FAIL zero_done: %0d/%0d pulses, required one each at cycle 1", dn0.size(), dn1.size());
      else passed++;
      total++; if (busy_seen0 || busy_seen1) $display("FAIL zero_busy: busy %0d/%0d, required 0", busy_seen0, busy_seen1); else passed++;
   endtask

   task automatic test_start_ignored();
      bit ok;
      int b;
      fill_ram();
      rmode = 1;
      b = $urandom_range(0, DEPTH - 1);
      build_exp(b, 8);
      issue_start(b, 8, 1'b0);
      @(posedge clka); #1;
      base_addr = AW'(b + 300); length = LW'(5); start = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
      wait_done(300, ok);
      repeat (8) @(negedge clka);
      rmode = 0;
      total++; if (!ok || stream_err(hs0) != -1) $display("FAIL ignore_l2: error %0d, got %0d words, required 8", stream_err(hs0), hs0.size()); else passed++;
      total++; if (stream_err(hs1) != -1) $display("FAIL ignore_l1: error %0d, got %0d words, required 8", stream_err(hs1), hs1.size()); else passed++;
      total++; if (dn0.size() != 1 || dn1.size() != 1) $display("FAIL ignore_done: %0d/%0d pulses, required 1/1", dn0.size(), dn1.size()); else passed++;
   endtask

   task automatic test_reset_mid();
      bit ok, quiet;
      logic [33:0] got0, got1;
      fill_ram();
      rmode = 0;
      issue_start($urandom_range(0, DEPTH - 1), 10, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clka); ok = (hs0.size() >= 3); end
      total++; if (!ok) $display("FAIL rstmid_wait: %0d handshakes in 50 cycles, required 3", hs0.size()); else passed++;
      @(posedge clka); #1 rstb = 1'b1;
      @(posedge clka); #1 rstb = 1'b0;
      @(negedge clka);
      got0 = {busy0, done0, s0.valid, s0.last, s0.data, enb0, addrb0, regceb0};
      got1 = {busy1, done1, s1.valid, s1.last, s1.data, enb1, addrb1, regceb1};
      total++; if (got0 !== 34'h1 || got1 !== 34'h1) $display("FAIL rstmid_outputs: %h/%h, required %h", got0, got1, 34'h1); else passed++;
      quiet = 1'b1;
      repeat (5) begin @(negedge clka); if (s0.valid || s1.valid || enb0 || enb1) quiet = 1'b0; end
      total++; if (!quiet) $display("FAIL rstmid_quiet: activity %0d after reset, required 0", !quiet); else passed++;
      build_exp(100, 2);
      issue_start(100, 2, 1'b0);
      wait_done(100, ok);
      repeat (2) @(negedge clka);
      total++; if (!ok || stream_err(hs0) != -1 || stream_err(hs1) != -1)
         $display("FAIL rstmid_stream: errors %0d/%0d, words %0d/%0d, required 2 each", stream_err(hs0), stream_err(hs1), hs0.size(), hs1.size());
      else passed++;
   endtask

   task automatic test_back_to_back();
      bit got;
      int b;
      fill_ram();
      rmode = 0;
      build_exp(40, 6);
      issue_start(40, 6, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin @(posedge clka); #1; got = done0; end
      total++; if (!got || stream_err(hs0) != -1) $display("FAIL b2b_first: done %0d, stream error %0d", got, stream_err(hs0)); else passed++;
      b = $urandom_range(0, DEPTH - 1);
      build_exp(b, 5);
      issue_start(b, 5, 1'b1);
      wait_done(100, got);
      repeat (2) @(negedge clka);
      total++; if (!got || en_c0.size() == 0 || en_c0[0] != 1 || stream_err(hs0) != -1)
         $display("FAIL b2b_second: first read cycle %0d, required 1; stream error %0d",
                  (en_c0.size() > 0) ? en_c0[0] : -1, stream_err(hs0));
      else passed++;
   endtask

   task automatic test_random();
      bit ok;
      int b, len;
      fill_ram();
      for (int n = 0; n < 6; n++) begin
         rmode = 1;
         b   = $urandom_range(0, DEPTH - 1);
         len = $urandom_range(1, 48);
         build_exp(b, len);
         issue_start(b, len, 1'b0);
         wait_done(1000, ok);
         repeat (2) @(negedge clka);
         total++; if (!ok || stream_err(hs0) != -1 || stream_err(hs1) != -1)
            $display("FAIL rand_stream[%0d]: base %0d len %0d errors %0d/%0d", n, b, len, stream_err(hs0), stream_err(hs1));
         else passed++;
         total++; if (dn0.size() != 1 || hs0.size() == 0 || dn0[0] != hs0[hs0.size()-1].cyc + 1 ||
                      dn1.size() != 1 || hs1.size() == 0 || dn1[0] != hs1[hs1.size()-1].cyc + 1)
            $display("FAIL rand_done[%0d]: done %0d/%0d pulses, required one cycle after last handshake", n, dn0.size(), dn1.size());
         else passed++;
         total++; if (max0 > 4 || max1 > 4 || stall_bad0 != 0 || stall_bad1 != 0)
            $display("FAIL rand_flow[%0d]: outstanding %0d/%0d (max 4), unstable %0d/%0d", n, max0, max1, stall_bad0, stall_bad1);
         else passed++;
      end
      rmode = 0;
   endtask

   task automatic test_full_sweep();
      bit ok;
      fill_ram();
      rmode = 0;
      build_exp(0, 1024);
      issue_start(0, 1024, 1'b0);
      wait_done(1200, ok);
      repeat (2) @(negedge clka);
      total++; if (!ok) $display("FAIL sweep_timeout: done not seen in 1200 cycles"); else passed++;
      total++; if (fv1 != 3 || fv0 != 4) $display("FAIL sweep_first_valid: %0d/%0d, required 3/4", fv1, fv0); else passed++;
      total++; if (stream_err(hs1) != -1) $display("FAIL sweep_stream_l1: error %0d, got %0d words, required 1024", stream_err(hs1), hs1.size()); else passed++;
      total++; if (stream_err(hs0) != -1) $display("FAIL sweep_stream_l2: error %0d, got %0d words, required 1024", stream_err(hs0), hs0.size()); else passed++;
      total++; if (dn1.size() != 1 || hs1.size() == 0 || dn1[0] != hs1[hs1.size()-1].cyc + 1)
         $display("FAIL sweep_done_l1: %0d pulses at %0d, required one after last handshake", dn1.size(), (dn1.size() > 0) ? dn1[0] : -1);
      else passed++;
   endtask

   initial begin
      clear_logs();
      test_reset();
      test_basic();
      test_backpressure();
      test_wrap();
      test_zero_len();
      test_start_ignored();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_full_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/bram_stream_reader.md
# bram_stream_reader

Read-side engine for the block RAM buffer: on a start command it sweeps a contiguous, wrapping address range through the RAM read port and presents the words as a valid/ready stream. It hides the RAM's fixed read latency (1 or 2 cycles) behind a small skid FIFO, so downstream backpressure never loses or duplicates a word. It pairs with the existing write-side producer, which fills the buffer through the RAM write port.

## Interface
- RAM_WIDTH, 18, data word width; must match the RAM instance.
- RAM_DEPTH, 1024, RAM entries; ADDR_W = ceil(log2(RAM_DEPTH)) is derived, not set.
- READ_LATENCY, 2, RAM read latency: 2 for the output-register configuration, 1 for the low-latency configuration.
- FIFO_DEPTH, 4, skid FIFO entries; must be ≥ READ_LATENCY+2.

Ports:
- clka  in  1  clock; shared with the RAM read port.
- rstb  in  1  reset, synchronous, active-high.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_W  first word address.
- length  in  ADDR_W+1  word count; 0 to 2^(ADDR_W+1)-1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- mem_addrb  out  ADDR_W  RAM read address.
- mem_enb  out  1  RAM read enable; one word is issued per high cycle.
- mem_regceb  out  1  RAM output register enable; constant 1.
- mem_doutb  in  RAM_WIDTH  RAM read data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final word of the command.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE, start=1, length≠0: latch base_addr and length into the address and remaining counters; go to RUN; busy=1 next cycle.
- IDLE, start=1, length=0: no reads issued; done=1 next cycle; stay in IDLE; busy stays 0.
- start in RUN or DRAIN is ignored.
- RUN issue rule: mem_enb=1 when remaining≠0 and (outstanding − pop) < FIFO_DEPTH.
  - outstanding = reads in flight + FIFO occupancy.
  - pop = m_valid & m_ready.
- Each issue increments the address (wrapping RAM_DEPTH-1 → 0) and decrements remaining.
- Last issue moves RUN → DRAIN.
- Latency pipe: READ_LATENCY-stage shift register of valid bits plus a last flag. A word is written into the FIFO when it leaves the pipe.
- Stream rule: m_data and m_last come from the FIFO head; m_valid = FIFO not empty.
- Once m_valid=1, m_data and m_last hold stable until the handshake.
- DRAIN → IDLE on the handshake of the m_last word; done=1 and busy=0 in the following cycle.
- mem_addrb holds its last value when mem_enb=0.
- Reset mid-operation:
  - go to IDLE; clear counters, pipe valid bits and FIFO pointers.
  - data still in the RAM output register is discarded, never streamed.

## Timing
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, mem_enb=0, mem_addrb=0, mem_regceb=1.
- start sampled in cycle 0 → first mem_enb in cycle 1.
- Read issued in cycle t → data enters the FIFO at the end of cycle t+READ_LATENCY → m_valid in cycle t+READ_LATENCY+1.
- First m_valid: cycle 4 for READ_LATENCY=2, cycle 3 for READ_LATENCY=1.
- Throughput: 1 word/cycle sustained with m_ready=1; no bubbles after the first word.
- m_ready=0: issue stalls once outstanding reaches FIFO_DEPTH; in-flight words always have a free FIFO slot.
- Simultaneous push and pop in a full FIFO is legal; occupancy is unchanged.
- done follows the last handshake by exactly 1 cycle.
- A new start is accepted in the same cycle done is high, since the FSM is already in IDLE.

## Test plan
- RAM[i]=i, base 0, length 8, m_ready=1 → mem_enb high cycles 1–8; m_data 0..7 in cycles 4–11; m_last in cycle 11; done in cycle 12.
- length 16, m_ready low for cycles 3–12 then random → at most 4 reads outstanding; words 0..15 delivered in order, no loss or duplicate; m_data stable while stalled.
- base 1022, length 4, RAM_DEPTH 1024 → mem_addrb 1022, 1023, 0, 1; data RAM[1022], RAM[1023], RAM[0], RAM[1].
- length 0 → mem_enb never high; done in cycle 1; busy stays 0. A start while busy during a length-8 run → ignored; exactly 8 words delivered.
- rstb pulsed after the 3rd handshake of a length-10 run → all outputs at reset values next cycle. Then start base 100, length 2 → only RAM[100], RAM[101] appear, with m_last on the second word.
- READ_LATENCY=1, full sweep base 0, length 1024 → 1024 words in order; first m_valid in cycle 3; m_last on word 1023; done one cycle after that handshake.
